// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron core.
package lif_pkg;
  localparam int V_WIDTH = 8;
  localparam int I_WIDTH = 12;
  localparam logic [V_WIDTH-1:0] THR_DEFAULT = 8'd25;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_INTEGRATE  = 2'd1,
    ST_SPIKE      = 2'd2,
    ST_REFRACTORY = 2'd3
  } state_t;

  // Entry 0 means no leak; a shift of 0 would otherwise leak everything.
  localparam logic [3:0][2:0] LEAK_SHIFT = {3'd2, 3'd3, 3'd4, 3'd0};

  function automatic logic [V_WIDTH-1:0] leak_amount(input logic [V_WIDTH-1:0] v,
                                                     input logic [1:0] cfg);
    if (cfg == 2'd0) return '0;
    return v >> LEAK_SHIFT[cfg];
  endfunction
endpackage

// File: rtl/lif_adaptive_threshold.sv
// Adaptive firing threshold: steps up per spike, decays after quiet periods,
// and is clamped into [thr_min, thr_max] on every run cycle.
module lif_adaptive_threshold
  import lif_pkg::*;
#(
  parameter int THR_STEP     = 4,
  parameter int DECAY_PERIOD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic               tick,
  input  logic               hit,
  input  logic [V_WIDTH-1:0] thr_min,
  input  logic [V_WIDTH-1:0] thr_max,
  output logic [V_WIDTH-1:0] thr
);
  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DECAY_PERIOD - 1);

  logic [DW-1:0]      dcnt;
  logic [V_WIDTH:0]   sum;
  logic [V_WIDTH-1:0] op;
  logic [V_WIDTH-1:0] nxt;
  logic               decay;

  assign sum   = {1'b0, thr} + 9'(THR_STEP);
  assign decay = tick && (dcnt == D_LAST);

  always_comb begin
    op = thr;
    if (step)
      op = (sum > {1'b0, thr_max}) ? thr_max : sum[V_WIDTH-1:0];
    else if (decay)
      op = (thr > thr_min) ? thr - 8'd1 : thr_min;
    // An inverted range resolves to the floor.
    nxt = op;
    if (thr_max < thr_min || op < thr_min) nxt = thr_min;
    else if (op > thr_max)                 nxt = thr_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr  <= THR_DEFAULT;
      dcnt <= '0;
    end else if (run) begin
      thr <= nxt;
      if (hit || decay) dcnt <= '0;
      else if (tick)    dcnt <= dcnt + 1'b1;
    end
  end
endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron with two weighted inputs, leak, refractory period and adaptive threshold.
// Define LIF_SPIKE_COUNT_EN to build the saturating spike counter; otherwise spike_count is tied to 0.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int THR_STEP       = 4,
  parameter int DECAY_PERIOD   = 16,
  parameter int REFRACT_CYCLES = 3,
  parameter int V_RESET        = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] stim_a,
  input  logic [7:0] stim_b,
  input  logic [2:0] weight_a,
  input  logic [2:0] weight_b,
  input  logic [1:0] leak_config,
  input  logic [7:0] threshold_min,
  input  logic [7:0] threshold_max,
  input  logic       params_ready,
  output logic       spike_out,
  output logic [7:0] membrane,
  output logic [7:0] threshold_now,
  output logic [1:0] neuron_state,
  output logic [7:0] spike_count
);
  localparam int RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [RW-1:0]      R_LOAD = RW'(REFRACT_CYCLES);
  localparam logic [V_WIDTH-1:0] V_RST  = V_WIDTH'(V_RESET);

  state_t               state;
  logic [V_WIDTH-1:0]   v;
  logic [V_WIDTH-1:0]   thr;
  logic [RW-1:0]        rcnt;
  logic                 spike_r;
  logic                 param_lost;
  logic                 run;
  logic                 active;
  logic [I_WIDTH-1:0]   prod;
  logic [I_WIDTH-1:0]   cur;
  logic [V_WIDTH-1:0]   leak;
  logic [I_WIDTH:0]     v_sum;
  logic [V_WIDTH-1:0]   v_next;
  logic                 in_int;
  logic                 fire;

  assign run    = enable & params_ready;
  assign active = run & ~param_lost;
  assign prod   = I_WIDTH'(stim_a) * I_WIDTH'(weight_a) + I_WIDTH'(stim_b) * I_WIDTH'(weight_b);
  assign cur    = prod >> 3;
  assign leak   = leak_amount(v, leak_config);
  assign v_sum  = {5'b0, v - leak} + {1'b0, cur};
  assign v_next = (v_sum > 13'd255) ? 8'd255 : v_sum[V_WIDTH-1:0];
  assign in_int = active && (state == ST_INTEGRATE);
  assign fire   = in_int && (v_next >= thr);

  lif_adaptive_threshold #(
    .THR_STEP    (THR_STEP),
    .DECAY_PERIOD(DECAY_PERIOD)
  ) u_thr (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .step   (active && (state == ST_SPIKE)),
    .tick   (in_int && !fire),
    .hit    (fire),
    .thr_min(threshold_min),
    .thr_max(threshold_max),
    .thr    (thr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      v          <= '0;
      rcnt       <= '0;
      spike_r    <= 1'b0;
      param_lost <= 1'b0;
    end else begin
      spike_r <= 1'b0;
      // Losing parameters mid-run forces a fresh pass through IDLE on resume.
      if (!params_ready && state != ST_IDLE) param_lost <= 1'b1;
      if (run) begin
        if (param_lost) begin
          param_lost <= 1'b0;
          state      <= ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: state <= ST_INTEGRATE;
            ST_INTEGRATE: begin
              if (fire) begin
                v       <= V_RST;
                spike_r <= 1'b1;
                state   <= ST_SPIKE;
              end else begin
                v <= v_next;
              end
            end
            ST_SPIKE: begin
              if (REFRACT_CYCLES == 0) begin
                state <= ST_INTEGRATE;
              end else begin
                rcnt  <= R_LOAD;
                state <= ST_REFRACTORY;
              end
            end
            ST_REFRACTORY: begin
              v <= V_RST;
              if (rcnt <= RW'(1)) begin
                rcnt  <= '0;
                state <= ST_INTEGRATE;
              end else begin
                rcnt <= rcnt - 1'b1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (fire && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end
  assign spike_count = cnt;
`else
  assign spike_count = '0;
`endif

  assign spike_out     = spike_r;
  assign membrane      = v;
  assign threshold_now = thr;
  assign neuron_state  = state;
endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed self-checking bench for lif_neuron_core.
module tb_lif_neuron_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] stim_a = '0, stim_b = '0;
  logic [2:0] weight_a = '0, weight_b = '0;
  logic [1:0] leak_config = '0;
  logic [7:0] threshold_min = 8'd10, threshold_max = 8'd85;
  logic       params_ready = 1'b0;
  logic       spike_out;
  logic [7:0] membrane, threshold_now, spike_count;
  logic [1:0] neuron_state;

  int errors = 0;
  int checks = 0;

`ifdef LIF_SPIKE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic [7:0] leak_exp [11] = '{8'd5, 8'd9, 8'd12, 8'd14, 8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd20, 8'd20};

  lif_neuron_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .stim_a       (stim_a),
    .stim_b       (stim_b),
    .weight_a     (weight_a),
    .weight_b     (weight_b),
    .leak_config  (leak_config),
    .threshold_min(threshold_min),
    .threshold_max(threshold_max),
    .params_ready (params_ready),
    .spike_out    (spike_out),
    .membrane     (membrane),
    .threshold_now(threshold_now),
    .neuron_state (neuron_state),
    .spike_count  (spike_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1; params_ready = 1'b1;
    stim_a = '0; stim_b = '0; weight_a = '0; weight_b = '0; leak_config = '0;
    threshold_min = 8'd10; threshold_max = 8'd85;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (membrane !== 8'd0) begin errors++; $display("FAIL reset_membrane got=%0d exp=0", membrane); end
    checks++; if (threshold_now !== 8'd25) begin errors++; $display("FAIL reset_thr got=%0d exp=25", threshold_now); end
    checks++; if (spike_out !== 1'b0) begin errors++; $display("FAIL reset_spike got=%b exp=0", spike_out); end
    checks++; if (neuron_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", neuron_state); end
    checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", spike_count); end
    weight_a = 3'd3; stim_a = 8'd40;
    tick();
    tick();
    checks++; if (membrane !== 8'd15) begin errors++; $display("FAIL pre_async_membrane got=%0d exp=15", membrane); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (membrane !== 8'd0) begin errors++; $display("FAIL async_membrane got=%0d exp=0", membrane); end
    checks++; if (threshold_now !== 8'd25) begin errors++; $display("FAIL async_thr got=%0d exp=25", threshold_now); end
    checks++; if (spike_out !== 1'b0) begin errors++; $display("FAIL async_spike got=%b exp=0", spike_out); end
    checks++; if (neuron_state !== 2'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", neuron_state); end
  endtask

  task automatic test_basic_spike();
    do_reset();
    weight_a = 3'd3; stim_a = 8'd40;
    tick();
    checks++; if (neuron_state !== 2'd1 || membrane !== 8'd0) begin errors++; $display("FAIL basic_idle_exit state=%0d v=%0d exp state=1 v=0", neuron_state, membrane); end
    tick();
    checks++; if (membrane !== 8'd15 || spike_out !== 1'b0) begin errors++; $display("FAIL basic_v1 v=%0d spike=%b exp v=15 spike=0", membrane, spike_out); end
    tick();
    checks++; if (spike_out !== 1'b1 || neuron_state !== 2'd2 || membrane !== 8'd0 || threshold_now !== 8'd25) begin
      errors++; $display("FAIL basic_fire spike=%b state=%0d v=%0d thr=%0d exp 1/2/0/25", spike_out, neuron_state, membrane, threshold_now); end
    tick();
    checks++; if (spike_out !== 1'b0 || threshold_now !== 8'd29 || neuron_state !== 2'd3) begin
      errors++; $display("FAIL basic_after spike=%b thr=%0d state=%0d exp 0/29/3", spike_out, threshold_now, neuron_state); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (neuron_state !== 2'd3 || membrane !== 8'd0) begin errors++; $display("FAIL basic_refract%0d state=%0d v=%0d exp 3/0", i, neuron_state, membrane); end
    end
    tick();
    checks++; if (neuron_state !== 2'd1) begin errors++; $display("FAIL basic_reenter state=%0d exp=1", neuron_state); end
    tick();
    checks++; if (membrane !== 8'd15) begin errors++; $display("FAIL basic_v2 v=%0d exp=15", membrane); end
  endtask

  task automatic test_leak_equilibrium();
    do_reset();
    weight_a = 3'd5; stim_a = 8'd8; leak_config = 2'd3;
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (membrane !== leak_exp[i] || spike_out !== 1'b0) begin
        errors++; $display("FAIL leak_step%0d v=%0d spike=%b exp v=%0d spike=0", i, membrane, spike_out, leak_exp[i]); end
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    weight_a = 3'd7; weight_b = 3'd7; stim_a = 8'd255; stim_b = 8'd255;
    threshold_min = 8'd200; threshold_max = 8'd100;
    tick();
    checks++; if (threshold_now !== 8'd200) begin errors++; $display("FAIL sat_inverted_clamp thr=%0d exp=200", threshold_now); end
    tick();
    checks++; if (spike_out !== 1'b1 || neuron_state !== 2'd2 || membrane !== 8'd0) begin
      errors++; $display("FAIL sat_fire spike=%b state=%0d v=%0d exp 1/2/0", spike_out, neuron_state, membrane); end
    enable = 1'b0;
    tick();
    tick();
    checks++; if (spike_out !== 1'b0 || neuron_state !== 2'd2 || threshold_now !== 8'd200) begin
      errors++; $display("FAIL sat_enable_freeze spike=%b state=%0d thr=%0d exp 0/2/200", spike_out, neuron_state, threshold_now); end
    enable = 1'b1;
    tick();
    checks++; if (neuron_state !== 2'd3 || threshold_now !== 8'd200) begin
      errors++; $display("FAIL sat_resume state=%0d thr=%0d exp 3/200", neuron_state, threshold_now); end

    do_reset();
    weight_a = 3'd7; weight_b = 3'd7; stim_a = 8'd255; stim_b = 8'd255;
    tick();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spike_out) n++;
    end
    checks++; if (n != 20) begin errors++; $display("FAIL sat_series_spikes got=%0d exp=20", n); end
    checks++; if (threshold_now !== 8'd85) begin errors++; $display("FAIL sat_thr_ceiling thr=%0d exp=85", threshold_now); end
    checks++; if (spike_count !== (CNT_EN ? 8'd20 : 8'd0)) begin
      errors++; $display("FAIL sat_count got=%0d exp=%0d", spike_count, CNT_EN ? 20 : 0); end
  endtask

  task automatic test_decay_freeze();
    bit found;
    do_reset();
    weight_a = 3'd7; stim_a = 8'd255;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (threshold_now == 8'd45) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL decay_reach45 thr=%0d exp=45", threshold_now); end
    stim_a = 8'd0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (neuron_state == 2'd1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL decay_enter_integrate state=%0d exp=1", neuron_state); end
    for (int i = 0; i < 15; i++) tick();
    checks++; if (threshold_now !== 8'd45) begin errors++; $display("FAIL decay_15 thr=%0d exp=45", threshold_now); end
    tick();
    checks++; if (threshold_now !== 8'd44) begin errors++; $display("FAIL decay_16 thr=%0d exp=44", threshold_now); end
    for (int i = 0; i < 48; i++) tick();
    checks++; if (threshold_now !== 8'd41 || neuron_state !== 2'd1 || membrane !== 8'd0) begin
      errors++; $display("FAIL decay_64 thr=%0d state=%0d v=%0d exp 41/1/0", threshold_now, neuron_state, membrane); end

    weight_a = 3'd1; stim_a = 8'd40;
    tick();
    checks++; if (membrane !== 8'd5) begin errors++; $display("FAIL freeze_pre v=%0d exp=5", membrane); end
    params_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({membrane, threshold_now, neuron_state, spike_out} !== {8'd5, 8'd41, 2'd1, 1'b0}) begin
        errors++; $display("FAIL freeze_hold%0d v=%0d thr=%0d state=%0d spike=%b exp 5/41/1/0", i, membrane, threshold_now, neuron_state, spike_out); end
    end
    params_ready = 1'b1;
    tick();
    checks++; if (neuron_state !== 2'd0 || membrane !== 8'd5) begin
      errors++; $display("FAIL freeze_idle state=%0d v=%0d exp 0/5", neuron_state, membrane); end
    tick();
    checks++; if (neuron_state !== 2'd1) begin errors++; $display("FAIL freeze_restart state=%0d exp=1", neuron_state); end
    tick();
    checks++; if (membrane !== 8'd10) begin errors++; $display("FAIL freeze_integrate v=%0d exp=10", membrane); end
  endtask

  task automatic test_spike_count();
    int n;
    do_reset();
    weight_a = 3'd7; stim_a = 8'd255;
    tick();
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (spike_out) n++;
    end
    checks++; if (n != 300) begin errors++; $display("FAIL count_spikes got=%0d exp=300", n); end
    checks++; if (spike_count !== (CNT_EN ? 8'd255 : 8'd0)) begin
      errors++; $display("FAIL count_saturate got=%0d exp=%0d", spike_count, CNT_EN ? 255 : 0); end
  endtask

  initial begin
    test_reset();
    test_basic_spike();
    test_leak_equilibrium();
    test_saturation();
    test_decay_freeze();
    test_spike_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
